// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the GCD result binary-to-BCD converter.
package gcd_pkg;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
   import gcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/gcd_result_bcd.sv
// Watches the data-memory GCD result word and converts each new value to packed BCD,
// one bit per cycle, handing the digits out through a valid/ready handshake.
module gcd_result_bcd
   import gcd_pkg::*;
#(
   parameter int WIDTH  = gcd_pkg::WIDTH,
   parameter int DIGITS = gcd_pkg::DIGITS
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      gcd_answer,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   input  logic                  bcd_ready,
   output logic                  busy
);

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   bcd_state_t          state_q, state_d;
   logic [WIDTH-1:0]    last_q,  last_d;
   logic [WIDTH-1:0]    bin_q,   bin_d;
   logic [4*DIGITS-1:0] acc_q,   acc_d;
   logic [5:0]          cnt_q,   cnt_d;
   logic [4*DIGITS-1:0] bcd_q,   bcd_d;

   logic [4*DIGITS-1:0] acc_adj;
   logic [4*DIGITS-1:0] acc_shift;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit_i (acc_q[4*gi +: 4]),
            .digit_o (acc_adj[4*gi +: 4])
         );
      end
   endgenerate

   // The MSB of the binary shift register feeds the units bit of the accumulator.
   assign acc_shift = {acc_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (gcd_answer != last_q) begin
               bin_d   = gcd_answer;
               last_d  = gcd_answer;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            acc_d = acc_shift;
            bin_d = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
               bcd_d   = acc_shift;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bcd_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= '0;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   assign bcd       = bcd_q;
   assign bcd_valid = (state_q == DONE);
   assign busy      = (state_q == CONVERT);

endmodule

// File: tb/tb_gcd_result_bcd.sv
// Scoreboard bench: the stimulus side pushes decimal-derived expected digits,
// a monitor pops and compares on every accepted handshake.
module tb_gcd_result_bcd;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] gcd_answer;
   logic [39:0] bcd;
   logic        bcd_valid;
   logic        bcd_ready;
   logic        busy;

   gcd_result_bcd dut (
      .clk        (clk),
      .rst        (rst),
      .gcd_answer (gcd_answer),
      .bcd        (bcd),
      .bcd_valid  (bcd_valid),
      .bcd_ready  (bcd_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [39:0] exp_q[$];
   int          checks = 0;
   int          passes = 0;
   int          pops   = 0;
   int          ready_mode = 1;   // 0 random, 1 always high, 2 always low
   logic [31:0] model_last = 32'd0;

   function automatic logic [39:0] to_bcd(input logic [31:0] v);
      logic [39:0] r;
      longint      x;
      r = '0;
      x = longint'(v);
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req)
         $display("FAIL %s got=%h required=%h", name, got, req);
      else
         passes++;
   endtask

   // Ready changes just after the rising edge so the monitor sees a stable value.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bcd_ready = ($urandom_range(0, 9) < 6);
         1:       bcd_ready = 1'b1;
         default: bcd_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (!rst && bcd_valid && bcd_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output got=%h required=none", bcd);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("bcd_out", {24'd0, bcd}, {24'd0, e});
            $display("txn %0d: bcd=%h expected=%h", pops, bcd, e);
         end
         pops++;
      end
   end

   task automatic drive(input logic [31:0] v);
      @(negedge clk);
      gcd_answer = v;
      if (v != model_last) begin
         exp_q.push_back(to_bcd(v));
         model_last = v;
      end
   endtask

   task automatic wait_pops(input int n, input string name);
      int k;
      k = 0;
      while (pops < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      if (pops < n) begin
         checks++;
         $display("FAIL %s_timeout got=%0d required=%0d", name, pops, n);
      end
   endtask

   initial begin
      int busy_cnt, valid_cnt, bad;
      logic [31:0] v;

      rst        = 1'b1;
      gcd_answer = 32'd0;
      bcd_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_bcd",   {24'd0, bcd}, 64'd0);
      check("reset_valid", {63'd0, bcd_valid}, 64'd0);
      check("reset_busy",  {63'd0, busy}, 64'd0);

      // Zero equals the reset value of the last capture, so nothing happens.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy || bcd_valid || bcd != 40'h0) bad++;
      end
      check("zero_idle", 64'(bad), 64'd0);

      // 21 with ready high: 32 busy cycles, one valid cycle.
      ready_mode = 1;
      drive(32'd21);
      busy_cnt  = 0;
      valid_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (bcd_valid) valid_cnt++;
      end
      check("busy_cycles",  64'(busy_cnt), 64'd32);
      check("valid_cycles", 64'(valid_cnt), 64'd1);
      wait_pops(1, "val21");
      check("hold_after_ack", {24'd0, bcd}, 64'h0000000021);

      drive(32'hFFFF_FFFF);
      wait_pops(2, "max");

      // Backpressure: output must hold while the input moves on.
      @(posedge clk);
      ready_mode = 2;
      @(posedge clk);
      drive(32'd6);
      begin
         int k;
         k = 0;
         while (!bcd_valid && k < 100) begin
            @(negedge clk);
            k++;
         end
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) begin
            gcd_answer = 32'd9;
            exp_q.push_back(to_bcd(32'd9));
            model_last = 32'd9;
         end
         @(negedge clk);
         if (!bcd_valid || bcd != 40'h06) bad++;
      end
      check("stall_hold", 64'(bad), 64'd0);
      ready_mode = 1;
      wait_pops(4, "stall");

      // Values written during CONVERT are dropped except the one present on return.
      @(negedge clk);
      gcd_answer = 32'd12;
      exp_q.push_back(to_bcd(32'd12));
      repeat (5) @(negedge clk);
      gcd_answer = 32'd18;
      repeat (5) @(negedge clk);
      gcd_answer = 32'd24;
      exp_q.push_back(to_bcd(32'd24));
      model_last = 32'd24;
      wait_pops(6, "drop");

      // Reset in the middle of converting 1071.
      @(negedge clk);
      gcd_answer = 32'd1071;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy",  {63'd0, busy}, 64'd0);
      check("abort_valid", {63'd0, bcd_valid}, 64'd0);
      check("abort_bcd",   {24'd0, bcd}, 64'd0);
      rst = 1'b0;
      model_last = 32'd0;
      exp_q.push_back(to_bcd(32'd1071));
      model_last = 32'd1071;
      wait_pops(7, "reconv");

      // Randomized traffic with random ready, occasional repeats of the last value.
      ready_mode = 0;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 3))
            0:       v = model_last;
            1:       v = $urandom_range(0, 99);
            default: v = $urandom;
         endcase
         drive(v);
         if (exp_q.size() != 0)
            wait_pops(pops + 1, "random");
         else
            repeat (5) @(negedge clk);
      end

      repeat (40) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
